// File: rtl/credit_link_pkg.sv
// =============================================================================
// credit_link_pkg : shared link-state encoding for the credit-based sender.
// Revision 1.0
// =============================================================================
`default_nettype none

package credit_link_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        DONE   = 2'd2
    } link_state_e;

endpackage

`default_nettype wire

// File: rtl/credit_counter.sv
// =============================================================================
// credit_counter : remote free-space counter with sticky overflow flag.
// Revision 1.0
// =============================================================================
`default_nettype none

module credit_counter #(
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 take,
    input  logic                 give,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 zero,
    output logic                 full,
    output logic                 overflow
);

    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT  = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_set;

    always_comb begin
        cnt_d   = cnt_q;
        ovf_set = 1'b0;
        unique case ({take, give})
            2'b10:   cnt_d = cnt_q - ONE_CNT;
            2'b01: begin
                // A credit that would exceed the remote depth is dropped and flagged.
                if (cnt_q == FULL_CNT) ovf_set = 1'b1;
                else                   cnt_d   = cnt_q + ONE_CNT;
            end
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= FULL_CNT;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (ovf_set) ovf_q <= 1'b1;
        end
    end

    assign count    = cnt_q;
    assign zero     = (cnt_q == '0);
    assign full     = (cnt_q == FULL_CNT);
    assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: rtl/credit_fifo_sender.sv
// =============================================================================
// credit_fifo_sender : transmit side of a credit link into a remote FIFO.
// Revision 1.0
// =============================================================================
`default_nettype none

module credit_fifo_sender
    import credit_link_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  DEPTH      = 8,
    parameter type dtype      = logic [DATA_WIDTH-1:0],
    parameter int  CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  dtype                 data_i,
    output logic                 push_o,
    output dtype                 data_o,
    input  logic                 credit_i,
    input  logic                 drain_i,
    output logic                 drain_done_o,
    output logic [CNT_WIDTH-1:0] credits_o,
    output logic                 err_o
);

    link_state_e state_q, state_d;
    logic        accept;
    logic        cnt_zero, cnt_full;
    logic        push_q;
    dtype        data_q;

    credit_counter #(
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_credit_counter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .take     (accept),
        .give     (credit_i),
        .count    (credits_o),
        .zero     (cnt_zero),
        .full     (cnt_full),
        .overflow (err_o)
    );

    // Ready depends only on registered state so upstream sees no comb loop.
    assign ready_o = (state_q == ACTIVE) && !cnt_zero;
    assign accept  = valid_i && ready_o;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACTIVE: if (drain_i) state_d = DRAIN;
            DRAIN: begin
                if (!drain_i)                 state_d = ACTIVE;
                else if (cnt_full && !push_q) state_d = DONE;
            end
            DONE:   if (!drain_i) state_d = ACTIVE;
            default: state_d = ACTIVE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ACTIVE;
            push_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            push_q  <= accept;
            if (accept) data_q <= data_i;
        end
    end

    assign push_o       = push_q;
    assign data_o       = data_q;
    assign drain_done_o = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_credit_fifo_sender.sv
// =============================================================================
// tb_credit_fifo_sender : directed self-checking bench for credit_fifo_sender.
// Revision 1.0
// =============================================================================
`default_nettype none

module tb_credit_fifo_sender;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_i;
    logic        push_o;
    logic [31:0] data_o;
    logic        credit_i;
    logic        drain_i;
    logic        drain_done_o;
    logic [3:0]  credits_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;

    credit_fifo_sender dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .push_o       (push_o),
        .data_o       (data_o),
        .credit_i     (credit_i),
        .drain_i      (drain_i),
        .drain_done_o (drain_done_o),
        .credits_o    (credits_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni   = 1'b0;
        valid_i  = 1'b0;
        data_i   = '0;
        credit_i = 1'b0;
        drain_i  = 1'b0;
        tick();
        tick();
        #2 rst_ni = 1'b1;
        #2;

        check("rst_credits", 32'(credits_o), 32'd8);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_push", 32'(push_o), 32'd0);
        check("rst_done", 32'(drain_done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_data", data_o, 32'd0);
        tick();

        // Stream ten items with no returning credit: only eight go out.
        for (int i = 0; i < 10; i++) begin
            valid_i = 1'b1;
            data_i  = 32'h10 + 32'(i);
            check($sformatf("stream_ready_%0d", i), 32'(ready_o), (i < 8) ? 32'd1 : 32'd0);
            tick();
            check($sformatf("stream_push_%0d", i), 32'(push_o), (i < 8) ? 32'd1 : 32'd0);
            check($sformatf("stream_data_%0d", i), data_o, (i < 8) ? 32'h10 + 32'(i) : 32'h17);
            check($sformatf("stream_cred_%0d", i), 32'(credits_o), (i < 8) ? 32'(7 - i) : 32'd0);
        end
        valid_i = 1'b0;
        check("empty_ready", 32'(ready_o), 32'd0);

        // A credit at zero reopens ready on the next cycle.
        credit_i = 1'b1;
        tick();
        check("cred1_ready", 32'(ready_o), 32'd1);
        check("cred1_count", 32'(credits_o), 32'd1);
        check("cred1_push", 32'(push_o), 32'd0);
        tick();
        tick();
        credit_i = 1'b0;
        check("cred3_count", 32'(credits_o), 32'd3);

        // Accept and credit together leave the count unchanged.
        valid_i  = 1'b1;
        data_i   = 32'hAA;
        credit_i = 1'b1;
        tick();
        valid_i  = 1'b0;
        credit_i = 1'b0;
        check("both_count", 32'(credits_o), 32'd3);
        check("both_push", 32'(push_o), 32'd1);
        check("both_data", data_o, 32'hAA);

        credit_i = 1'b1;
        repeat (5) tick();
        credit_i = 1'b0;
        check("refill_count", 32'(credits_o), 32'd8);
        check("refill_err", 32'(err_o), 32'd0);

        // Overflow: extra credit at full is dropped and flagged stickily.
        credit_i = 1'b1;
        tick();
        credit_i = 1'b0;
        check("ovf_count", 32'(credits_o), 32'd8);
        check("ovf_err", 32'(err_o), 32'd1);
        tick();
        check("ovf_sticky", 32'(err_o), 32'd1);

        // Drain with two items outstanding.
        valid_i = 1'b1;
        data_i  = 32'h21;
        tick();
        data_i  = 32'h22;
        tick();
        valid_i = 1'b0;
        check("pre_drain_count", 32'(credits_o), 32'd6);
        drain_i = 1'b1;
        tick();
        check("drain_ready", 32'(ready_o), 32'd0);
        check("drain_done0", 32'(drain_done_o), 32'd0);
        credit_i = 1'b1;
        tick();
        tick();
        credit_i = 1'b0;
        check("drain_count8", 32'(credits_o), 32'd8);
        check("drain_done_early", 32'(drain_done_o), 32'd0);
        tick();
        check("drain_done1", 32'(drain_done_o), 32'd1);
        check("done_ready", 32'(ready_o), 32'd0);
        drain_i = 1'b0;
        tick();
        check("undrain_done", 32'(drain_done_o), 32'd0);
        check("undrain_ready", 32'(ready_o), 32'd1);
        check("err_still", 32'(err_o), 32'd1);

        // Accept in the same cycle drain rises still issues its push.
        valid_i = 1'b1;
        data_i  = 32'h33;
        drain_i = 1'b1;
        check("drainrise_ready", 32'(ready_o), 32'd1);
        tick();
        valid_i = 1'b0;
        check("drainrise_push", 32'(push_o), 32'd1);
        check("drainrise_data", data_o, 32'h33);
        check("drainrise_ready_after", 32'(ready_o), 32'd0);
        check("drainrise_count", 32'(credits_o), 32'd7);

        // Reach DRAIN with five credits and a push in flight, then reset.
        drain_i = 1'b0;
        tick();
        valid_i = 1'b1;
        data_i  = 32'h34;
        tick();
        data_i  = 32'h35;
        drain_i = 1'b1;
        tick();
        valid_i = 1'b0;
        check("mid_count", 32'(credits_o), 32'd5);
        check("mid_push", 32'(push_o), 32'd1);
        check("mid_ready", 32'(ready_o), 32'd0);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_count", 32'(credits_o), 32'd8);
        check("arst_push", 32'(push_o), 32'd0);
        check("arst_ready", 32'(ready_o), 32'd1);
        check("arst_err", 32'(err_o), 32'd0);
        check("arst_data", data_o, 32'd0);
        drain_i = 1'b0;
        tick();
        #2 rst_ni = 1'b1;

        // Link resumes normally after reset.
        tick();
        valid_i = 1'b1;
        data_i  = 32'h5A;
        tick();
        valid_i = 1'b0;
        check("post_push", 32'(push_o), 32'd1);
        check("post_data", data_o, 32'h5A);
        check("post_count", 32'(credits_o), 32'd7);
        tick();
        check("post_idle_push", 32'(push_o), 32'd0);
        check("post_hold_data", data_o, 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
